frv_gf256_alu: RTL and testbench
================================

# frv_gf256_alu

Multi-cycle packed GF(2^8) arithmetic unit for the core's crypto datapath, using the polynomial x^8 + x^4 + x^3 + x + 1. It accepts one 32-bit operation at a time over a valid/ready handshake. It drives four lane instances of the combinational frv_gf256_mul multiplier, one per byte, and holds each result until it is consumed. Two operations are supported:
- packed multiply, rs1 × rs2 bytewise;
- packed inverse of rs1, computed as a^254 by square-and-multiply, with inv(0) = 0.

## Interface
Parameters: none.

Ports (clock and reset first):
- g_clk  in  1  core clock; all state changes on its rising edge.
- g_reset  in  1  reset, synchronous and active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  1  0 = packed multiply, 1 = packed inverse.
- in_rs1  in  32  operand A, four byte lanes with [8i+7:8i] as lane i.
- in_rs2  in  32  operand B; ignored when in_op = 1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  packed result, lane i in [8i+7:8i].

## Operation
Registers:
- acc[31:0], the accumulator.
- opb[31:0], the fixed operand.
- op, the latched operation.
- step[3:0], the step counter.
- state ∈ {IDLE, BUSY, DONE}.

Each lane multiplies mul_a[8i+7:8i] × mul_b[8i+7:8i] through one frv_gf256_mul instance. Lanes are fully independent; there are no carries between bytes.

Accept: the request is accepted when state = IDLE and in_valid = 1. On that edge the unit loads:
- acc ← in_rs1;
- opb ← (in_op ? in_rs1 : in_rs2);
- op ← in_op;
- step ← 0;
- state ← BUSY.

BUSY: every cycle, acc ← mul(mul_a, mul_b) and step increments. Operand selection:
- mul_a = acc in all BUSY cycles.
- Multiply: mul_b = opb. The unit runs 1 step (step 0), then goes to DONE.
- Inverse: mul_b = acc (square) when step is even, and opb (multiply by a) when step is odd. The unit runs 13 steps (0..12), then goes to DONE.
- Inverse exponent sequence is a^1 → 2,3,6,7,14,15,30,31,62,63,126,127 → 254.

DONE: out_valid = 1 and out_result = acc.
- When out_ready = 1, state goes to IDLE.
- While out_ready = 0, acc and out_result are held stable.

Handshake signals:
- in_ready = (state == IDLE). A new request cannot be accepted in DONE, even when out_ready is high that cycle.
- in_rs1, in_rs2 and in_op are sampled only on the accept edge. Changes at any other time have no effect.
- out_result is driven from acc only; it is 0 when not in DONE.

Reset: g_reset = 1 at any edge forces the following, overriding every other transition, including mid-BUSY and in DONE while out_ready is low:
- state ← IDLE;
- acc, opb, step and op ← 0.

The in-flight operation is discarded and no result is produced for it.

## Timing
Reset values of the outputs: in_ready = 1, out_valid = 0, out_result = 0.

Latency, counted from the accept edge at cycle t:
- Multiply: BUSY during t+1; out_valid is first high in cycle t+2.
- Inverse: BUSY during t+1..t+13; out_valid is first high in cycle t+14.

Throughput:
- The result handshake at cycle d (out_valid && out_ready) puts the unit in IDLE at d+1.
- The earliest next accept is the edge at the end of d+1.
- Minimum request spacing is therefore 3 cycles for multiply and 15 cycles for inverse.

The combinational path is register → frv_gf256_mul → register, one multiply per cycle. There is no combinational path from in_* to out_*.

## Test plan
- Reset behaviour: assert g_reset mid-inverse, at step 5 → the next cycle shows in_ready = 1, out_valid = 0, out_result = 0, and no result appears afterwards.
- Packed multiply: in_rs1 = 0x0157_5757, in_rs2 = 0xFF13_8301, op = 0.
  - Required result: 0xFFFE_C157, i.e. lanes 0x57×0x01 = 0x57, 0x57×0x83 = 0xC1, 0x57×0x13 = 0xFE, 0x01×0xFF = 0xFF.
  - out_valid must be first high exactly 2 cycles after accept.
- Packed inverse: in_rs1 = 0x0002_0153, op = 1, in_rs2 = 0xDEADBEEF.
  - Required result: 0x008D_01CA.
  - in_rs2 must be ignored.
  - out_valid must be first high exactly 14 cycles after accept.
- Back-pressure: in DONE, hold out_ready = 0 for 7 cycles → out_result is stable and in_ready stays 0 throughout. Raise out_ready → IDLE on the next cycle.
- Operand isolation: change in_rs1 and in_op during BUSY → the result is unaffected. in_valid held high across DONE → accepted only once the unit is IDLE.
- Random: 1000 random multiply and inverse requests with random out_ready stalls, checked against a bytewise reference model. For inverse, a×inv(a) = 0x01 for every nonzero lane, and lanes with value 0x00 yield 0x00.

Source files
------------

// File: rtl/frv_gf256_alu.sv
// frv_gf256_alu: multi-cycle packed GF(2^8) multiply / inverse unit over x^8+x^4+x^3+x+1
module frv_gf256_mul (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_t;
  always_comb begin
    o_p = 8'h00;
    w_t = i_a;
    for (int k = 0; k < 8; k++) begin
      o_p = i_b[k] ? o_p ^ w_t : o_p;
      w_t = {w_t[6:0], 1'b0} ^ (w_t[7] ? 8'h1b : 8'h00);
    end
  end
endmodule

module frv_gf256_alu (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      r_state;
  logic [31:0] r_acc;
  logic [31:0] r_opb;
  logic        r_op;
  logic [3:0]  r_step;
  logic [31:0] w_mul_b;
  logic [31:0] w_mul;
  logic        w_last;
  // inverse alternates square (even step) and multiply-by-a (odd step) to reach a^254
  assign w_mul_b = (r_op && !r_step[0]) ? r_acc : r_opb;
  assign w_last  = r_op ? (r_step == 4'd12) : 1'b1;
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_lane
      frv_gf256_mul u_mul (
        .i_a(r_acc[8*i +: 8]),
        .i_b(w_mul_b[8*i +: 8]),
        .o_p(w_mul[8*i +: 8])
      );
    end
  endgenerate
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state <= IDLE;
      r_acc   <= 32'h0;
      r_opb   <= 32'h0;
      r_op    <= 1'b0;
      r_step  <= 4'd0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_acc   <= in_rs1;
        r_opb   <= in_op ? in_rs1 : in_rs2;
        r_op    <= in_op;
        r_step  <= 4'd0;
        r_state <= BUSY;
      end
    end else if (r_state == BUSY) begin
      r_acc  <= w_mul;
      r_step <= r_step + 4'd1;
      if (w_last) r_state <= DONE;
    end else if (out_ready) begin
      r_state <= IDLE;
    end
  end
  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign out_result = out_valid ? r_acc : 32'h0;
endmodule

// File: tb/tb_frv_gf256_alu.sv
// tb_frv_gf256_alu: vector table, corner sequences and random requests against a log/antilog model
module tb_frv_gf256_alu;
  logic        g_clk = 1'b0;
  logic        g_reset, in_valid, in_ready, in_op, out_valid, out_ready;
  logic [31:0] in_rs1, in_rs2, out_result;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  gexp [256];
  int          glog [256];

  always #5 g_clk = ~g_clk;

  frv_gf256_alu dut (
    .g_clk(g_clk), .g_reset(g_reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result)
  );

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  function automatic logic [7:0] m8(input logic [7:0] a, input logic [7:0] b);
    return (a == 0 || b == 0) ? 8'h00 : gexp[(glog[a] + glog[b]) % 255];
  endfunction

  function automatic logic [7:0] i8(input logic [7:0] a);
    return (a == 0) ? 8'h00 : gexp[(255 - glog[a]) % 255];
  endfunction

  function automatic logic [31:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = op ? i8(a[8*l +: 8]) : m8(a[8*l +: 8], b[8*l +: 8]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  task automatic run_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input int stall, output logic [31:0] res);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    chk("ready_before_req", {63'h0, in_ready}, 64'h1);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b;
    tick;
    in_valid = 1'b0; in_op = 1'($urandom); in_rs1 = $urandom; in_rs2 = $urandom;
    n = 0;
    while (!out_valid && n < 40) begin tick; n++; end
    chk("latency", 64'(n), op ? 64'd13 : 64'd1);
    res = out_result;
    for (int s = 0; s < stall; s++) begin
      tick;
      chk("stall_hold", {in_ready, out_valid, out_result}, {1'b0, 1'b1, res});
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("release_idle", {in_ready, out_valid, out_result}, {1'b1, 1'b0, 32'h0});
  endtask

  initial begin
    vec_t        vt [6];
    logic [7:0]  e;
    logic [31:0] res, a, b;
    logic        op, seen;
    int          n;
    e = 8'h01;
    for (int k = 0; k < 255; k++) begin
      gexp[k] = e;
      glog[e] = k;
      e = e ^ {e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00);
    end
    vt[0] = '{1'b0, 32'h0157_5757, 32'hFF13_8301, 32'hFFFE_C157};
    vt[1] = '{1'b0, 32'h0200_0057, 32'h80FF_0001, 32'h1B00_0057};
    vt[2] = '{1'b0, 32'h03F6_5313, 32'hF603_CA57, 32'h0101_01FE};
    vt[3] = '{1'b1, 32'h0002_0153, 32'hDEAD_BEEF, 32'h008D_01CA};
    vt[4] = '{1'b1, 32'hCA8D_F603, 32'h1234_5678, 32'h5302_03F6};
    vt[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    g_reset = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_rs1 = '0; in_rs2 = '0; out_ready = 1'b0;
    tick; tick;
    chk("reset_outputs", {in_ready, out_valid, out_result}, {1'b1, 1'b0, 32'h0});
    g_reset = 1'b0;

    foreach (vt[k]) begin
      run_req(vt[k].op, vt[k].a, vt[k].b, k, res);
      chk($sformatf("vector%0d", k), {32'h0, res}, {32'h0, vt[k].r});
    end

    run_req(1'b1, 32'h0002_0153, 32'hDEAD_BEEF, 7, res);
    chk("backpressure_result", {32'h0, res}, 64'h008D_01CA);

    // reset in the middle of an inverse, at step 5
    in_valid = 1'b1; in_op = 1'b1; in_rs1 = 32'h0002_0153;
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    g_reset = 1'b1;
    tick;
    chk("midbusy_reset", {in_ready, out_valid, out_result}, {1'b1, 1'b0, 32'h0});
    g_reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin tick; seen |= out_valid; end
    chk("no_result_after_reset", {63'h0, seen}, 64'h0);

    // operands changed during BUSY, in_valid held high across DONE
    in_valid = 1'b1; in_op = 1'b1; in_rs1 = 32'h0002_0153; in_rs2 = 32'hDEAD_BEEF;
    tick;
    in_op = 1'b0; in_rs1 = 32'h1234_5678; in_rs2 = 32'h1111_1111;
    n = 0;
    while (!out_valid && n < 40) begin tick; n++; end
    chk("iso_latency", 64'(n), 64'd13);
    chk("iso_result", {32'h0, out_result}, 64'h008D_01CA);
    tick;
    chk("iso_done_no_accept", {in_ready, out_valid, out_result}, {1'b0, 1'b1, 32'h008D_01CA});
    in_rs1 = 32'h0157_5757; in_rs2 = 32'hFF13_8301;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("iso_idle", {62'h0, in_ready, out_valid}, 64'h2);
    tick;
    in_valid = 1'b0;
    chk("iso_accepted", {63'h0, in_ready}, 64'h0);
    tick;
    chk("iso_second_result", {31'h0, out_valid, out_result}, {31'h0, 1'b1, 32'hFFFE_C157});
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    for (int k = 0; k < 1000; k++) begin
      op = 1'($urandom);
      a = $urandom;
      b = $urandom;
      if (($urandom & 7) == 0) a[8*$urandom_range(0, 3) +: 8] = 8'h00;
      run_req(op, a, b, $urandom_range(0, 3), res);
      chk("random", {32'h0, res}, {32'h0, model(op, a, b)});
      if (op)
        for (int l = 0; l < 4; l++)
          chk("inv_identity", 64'(m8(a[8*l +: 8], res[8*l +: 8])), (a[8*l +: 8] == 0) ? 64'h0 : 64'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
